board_display: RTL

BOARD_DISPLAY -- requirements
Module: board_display

---
 rtl/ttt_pkg.sv | 31 +++
 rtl/glyph_rom.sv | 36 +++
 rtl/board_display.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/ttt_pkg.sv
// Shared definitions for the tic-tac-toe dot-matrix display.
// Holds the cell codes, glyph row patterns (leftmost column in the MSB),
// grid column indices, matrix dimensions and the blink phase encoding.
package ttt_pkg;

  typedef enum logic [1:0] {
    CELL_EMPTY = 2'b00,
    CELL_X     = 2'b01,
    CELL_O     = 2'b10
  } cell_e;

  typedef enum logic {
    PHASE_BLANK = 1'b0,
    PHASE_SHOW  = 1'b1
  } phase_e;

  localparam logic [3:0] GLYPH_EMPTY = 4'b0000;
  localparam logic [3:0] GLYPH_X_G0  = 4'b1001;
  localparam logic [3:0] GLYPH_X_G1  = 4'b0110;
  localparam logic [3:0] GLYPH_X_G2  = 4'b1001;
  localparam logic [3:0] GLYPH_O_G0  = 4'b0110;
  localparam logic [3:0] GLYPH_O_G1  = 4'b1001;
  localparam logic [3:0] GLYPH_O_G2  = 4'b0110;

  localparam int unsigned MATRIX_ROWS = 10;
  localparam int unsigned MATRIX_COLS = 14;
  localparam int unsigned GRID_COL_L  = 4;
  localparam int unsigned GRID_COL_R  = 9;
  localparam int unsigned STATUS_ROW  = 9;

endpackage

// File: rtl/glyph_rom.sv
// Combinational glyph lookup.
//   code_i    : 2-bit cell code (00 empty, 01 X, 10 O, 11 shown as empty)
//   row_i     : glyph row 0..2 (3 yields a blank row)
//   pattern_o : 4-bit row pattern, bit 3 = leftmost column
module glyph_rom
  import ttt_pkg::*;
(
  input  logic [1:0] code_i,
  input  logic [1:0] row_i,
  output logic [3:0] pattern_o
);

  always_comb begin
    pattern_o = GLYPH_EMPTY;
    case (code_i)
      CELL_X: begin
        case (row_i)
          2'd0:    pattern_o = GLYPH_X_G0;
          2'd1:    pattern_o = GLYPH_X_G1;
          2'd2:    pattern_o = GLYPH_X_G2;
          default: pattern_o = GLYPH_EMPTY;
        endcase
      end
      CELL_O: begin
        case (row_i)
          2'd0:    pattern_o = GLYPH_O_G0;
          2'd1:    pattern_o = GLYPH_O_G1;
          2'd2:    pattern_o = GLYPH_O_G2;
          default: pattern_o = GLYPH_EMPTY;
        endcase
      end
      default: pattern_o = GLYPH_EMPTY;
    endcase
  end

endmodule

// File: rtl/board_display.sv
// Scanned 10x14 dot-matrix driver for a tic-tac-toe board.
//   clk, rst     : clock, asynchronous active-high reset
//   enable       : 1 = scan, 0 = dark (counters forced to reset values)
//   board        : 9 cells x 2 bits, cell k at board[2k+1:2k]
//   turn_o       : 0 = X to move, 1 = O to move (status row)
//   blink_mask   : bit k = 1 blinks cell k
//   dot_row      : one-hot active-high row select
//   dot_col      : pixel data, matrix column c on dot_col[13-c]
//   frame_start  : one-cycle pulse when a frame snapshot is taken
module board_display
  import ttt_pkg::*;
#(
  parameter int unsigned ROW_DIV      = 2499,
  parameter int unsigned BLINK_FRAMES = 50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [17:0] board,
  input  logic        turn_o,
  input  logic [8:0]  blink_mask,
  output logic [9:0]  dot_row,
  output logic [13:0] dot_col,
  output logic        frame_start
);

  localparam logic [15:0] DIV_MAX   = 16'(ROW_DIV);
  localparam logic [7:0]  FRAME_MAX = 8'(BLINK_FRAMES - 1);
  localparam logic [3:0]  LAST_ROW  = 4'(MATRIX_ROWS - 1);
  localparam int unsigned MSB_COL   = MATRIX_COLS - 1;

  logic [15:0] div_q, div_d;
  logic [3:0]  row_q, row_d;
  logic [7:0]  frame_q, frame_d;
  phase_e      phase_q, phase_d;
  phase_e      snap_phase_q, snap_phase_d;
  logic [17:0] board_q, board_d;
  logic        turn_q, turn_d;
  logic [8:0]  mask_q, mask_d;
  logic [9:0]  dot_row_q, dot_row_d;
  logic [13:0] dot_col_q, dot_col_d;
  logic        fs_q, fs_d;

  logic [3:0]  cell_base;
  logic [1:0]  glyph_row;
  logic [1:0]  cell_code [3];
  logic [3:0]  pat [3];
  logic [13:0] line;

  // Cells of the current cell row, with blinked cells forced empty during
  // the blank phase captured with the snapshot.
  always_comb begin
    logic [3:0] k;
    logic [1:0] code;
    cell_base = '0;
    glyph_row = 2'd3;
    k         = '0;
    code      = CELL_EMPTY;
    case (row_q)
      4'd0, 4'd1, 4'd2: begin cell_base = 4'd0; glyph_row = row_q[1:0];         end
      4'd3, 4'd4, 4'd5: begin cell_base = 4'd3; glyph_row = 2'(row_q - 4'd3);   end
      4'd6, 4'd7, 4'd8: begin cell_base = 4'd6; glyph_row = 2'(row_q - 4'd6);   end
      default:          begin cell_base = 4'd0; glyph_row = 2'd3;               end
    endcase
    for (int unsigned c = 0; c < 3; c++) begin
      k    = cell_base + 4'(c);
      code = board_q[{k, 1'b0} +: 2];
      if (snap_phase_q == PHASE_BLANK && mask_q[k]) code = CELL_EMPTY;
      cell_code[c] = code;
    end
  end

  glyph_rom u_glyph0 (.code_i(cell_code[0]), .row_i(glyph_row), .pattern_o(pat[0]));
  glyph_rom u_glyph1 (.code_i(cell_code[1]), .row_i(glyph_row), .pattern_o(pat[1]));
  glyph_rom u_glyph2 (.code_i(cell_code[2]), .row_i(glyph_row), .pattern_o(pat[2]));

  always_comb begin
    line = '0;
    if (row_q == 4'(STATUS_ROW)) begin
      if (turn_q) line[3:0] = 4'b1111;
      else        line[MSB_COL -: 4] = 4'b1111;
    end else begin
      line[MSB_COL -: 4]              = pat[0];
      line[MSB_COL - GRID_COL_L]      = 1'b1;
      line[MSB_COL - GRID_COL_L - 1 -: 4] = pat[1];
      line[MSB_COL - GRID_COL_R]      = 1'b1;
      line[3:0]                       = pat[2];
    end
  end

  // Phase toggles at the snapshot that ends a blink half-period; the frame
  // just starting still displays with the pre-toggle phase.
  always_comb begin
    div_d        = div_q;
    row_d        = row_q;
    frame_d      = frame_q;
    phase_d      = phase_q;
    snap_phase_d = snap_phase_q;
    board_d      = board_q;
    turn_d       = turn_q;
    mask_d       = mask_q;
    dot_row_d    = '0;
    dot_col_d    = '0;
    fs_d         = 1'b0;
    if (!enable) begin
      div_d   = '0;
      row_d   = '0;
      frame_d = '0;
      phase_d = PHASE_SHOW;
    end else begin
      if (row_q == '0 && div_q == '0) begin
        fs_d         = 1'b1;
        board_d      = board;
        turn_d       = turn_o;
        mask_d       = blink_mask;
        snap_phase_d = phase_q;
        if (frame_q == FRAME_MAX) begin
          frame_d = '0;
          phase_d = (phase_q == PHASE_SHOW) ? PHASE_BLANK : PHASE_SHOW;
        end else begin
          frame_d = frame_q + 8'd1;
        end
      end
      if (div_q == DIV_MAX) begin
        div_d = '0;
        row_d = (row_q == LAST_ROW) ? '0 : row_q + 4'd1;
      end else begin
        div_d = div_q + 16'd1;
      end
      if (div_q != '0) begin
        dot_row_d = 10'(1) << row_q;
        dot_col_d = line;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q        <= '0;
      row_q        <= '0;
      frame_q      <= '0;
      phase_q      <= PHASE_SHOW;
      snap_phase_q <= PHASE_BLANK;
      board_q      <= '0;
      turn_q       <= 1'b0;
      mask_q       <= '0;
      dot_row_q    <= '0;
      dot_col_q    <= '0;
      fs_q         <= 1'b0;
    end else begin
      div_q        <= div_d;
      row_q        <= row_d;
      frame_q      <= frame_d;
      phase_q      <= phase_d;
      snap_phase_q <= snap_phase_d;
      board_q      <= board_d;
      turn_q       <= turn_d;
      mask_q       <= mask_d;
      dot_row_q    <= dot_row_d;
      dot_col_q    <= dot_col_d;
      fs_q         <= fs_d;
    end
  end

  assign dot_row     = dot_row_q;
  assign dot_col     = dot_col_q;
  assign frame_start = fs_q;

endmodule
